fp_div_seq: RTL and testbench

- Multi-cycle IEEE 754 single-precision divider controller: accepts an operand pair (dividend A, divisor B) over a valid/ready handshake and decodes the fields and special classes using the team's `unpack` block.
- Resolves special cases in 1 cycle; otherwise it sequences a restoring mantissa divider (1 quotient bit/cycle), then normalize and round-to-nearest-even.
- Result plus exception flags are presented on a held output handshake. Sits between the FP issue logic and the writeback arbiter.

---
 rtl/fp_div_seq_if.sv | 27 ++
 rtl/fp_div_seq.sv | 277 +++++++++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/fp_div_seq_if.sv
// Operand/result handshake bundle between FP issue, the sequential divider and writeback.
interface fp_div_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] flp_a;
    logic [31:0] flp_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        flag_invalid;
    logic        flag_div_zero;
    logic        flag_overflow;
    logic        flag_underflow;
    logic        busy;

    modport master (
        output in_valid, flp_a, flp_b, out_ready,
        input  in_ready, out_valid, result, flag_invalid, flag_div_zero,
               flag_overflow, flag_underflow, busy
    );

    modport slave (
        input  in_valid, flp_a, flp_b, out_ready,
        output in_ready, out_valid, result, flag_invalid, flag_div_zero,
               flag_overflow, flag_underflow, busy
    );
endinterface

// File: rtl/fp_div_seq.sv
// Multi-cycle IEEE 754 single-precision divider: 1-cycle special resolution, otherwise a
// restoring divider (one quotient bit per cycle) followed by normalize and round-to-nearest-even.
module fp_div_seq #(
    parameter int QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_div_seq_if.slave dbus
);
    localparam int            CW       = $clog2(QBITS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(QBITS - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DIV   = 3'd1,
        S_NORM  = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] sig;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } fp_fields_t;

    // Field split and class decode; subnormals are deliberately classed as zero.
    function automatic fp_fields_t unpack(input logic [31:0] f);
        fp_fields_t u;
        u.sign    = f[31];
        u.exp     = f[30:23];
        u.sig     = f[22:0];
        u.is_zero = (f[30:23] == 8'd0);
        u.is_inf  = (f[30:23] == 8'hFF) && (f[22:0] == 23'd0);
        u.is_nan  = (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
        return u;
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       divisor_q, divisor_d;
    logic [QBITS-1:0]  quo_q, quo_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [23:0]       mant_q, mant_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [31:0]       result_q, result_d;
    logic              inv_q, inv_d;
    logic              dz_q, dz_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              out_valid_q, out_valid_d;

    fp_fields_t        ua_s, ub_s;
    logic              accept_s;
    logic              invalid_s;
    logic              special_s;
    logic [24:0]       trial_s;
    logic              qbit_s;
    logic              round_up_s;
    logic [24:0]       mant_inc_s;
    logic [23:0]       mant_rnd_s;
    logic signed [9:0] exp_rnd_s;

    // Operand classification and accept qualification.
    always_comb begin
        ua_s      = unpack(dbus.flp_a);
        ub_s      = unpack(dbus.flp_b);
        accept_s  = dbus.in_valid && (state_q == S_IDLE);
        invalid_s = ua_s.is_nan || ub_s.is_nan
                 || (ua_s.is_zero && ub_s.is_zero)
                 || (ua_s.is_inf && ub_s.is_inf);
        special_s = invalid_s || ua_s.is_inf || ua_s.is_zero
                 || ub_s.is_zero || ub_s.is_inf;
    end

    // Restoring trial subtraction and RNE increment; a carry-out renormalizes to 1.0.
    always_comb begin
        trial_s    = rem_q - {1'b0, divisor_q};
        qbit_s     = ~trial_s[24];
        round_up_s = guard_q && (sticky_q || mant_q[0]);
        mant_inc_s = {1'b0, mant_q} + 25'd1;
        if (!round_up_s) begin
            mant_rnd_s = mant_q;
            exp_rnd_s  = exp_q;
        end else if (mant_inc_s[24]) begin
            mant_rnd_s = 24'h800000;
            exp_rnd_s  = exp_q + 10'sd1;
        end else begin
            mant_rnd_s = mant_inc_s[23:0];
            exp_rnd_s  = exp_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = special_s ? S_DONE : S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV:   state_d = (cnt_q == CNT_ZERO) ? S_NORM : S_DIV;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE: begin
                if (dbus.out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values per state.
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        quo_d       = quo_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        mant_d      = mant_q;
        guard_d     = guard_q;
        sticky_d    = sticky_q;
        result_d    = result_q;
        inv_d       = inv_q;
        dz_d        = dz_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    sign_d = ua_s.sign ^ ub_s.sign;
                    inv_d  = 1'b0;
                    dz_d   = 1'b0;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (invalid_s) begin
                        result_d    = 32'h7FC00000;
                        inv_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else if (ua_s.is_inf) begin
                        result_d    = {ua_s.sign ^ ub_s.sign, 8'hFF, 23'd0};
                        out_valid_d = 1'b1;
                    end else if (ub_s.is_zero) begin
                        result_d    = {ua_s.sign ^ ub_s.sign, 8'hFF, 23'd0};
                        dz_d        = 1'b1;
                        out_valid_d = 1'b1;
                    end else if (special_s) begin
                        result_d    = {ua_s.sign ^ ub_s.sign, 31'd0};
                        out_valid_d = 1'b1;
                    end else begin
                        rem_d     = {2'b01, ua_s.sig};
                        divisor_d = {1'b1, ub_s.sig};
                        quo_d     = {QBITS{1'b0}};
                        cnt_d     = CNT_LOAD;
                        exp_d     = $signed({2'b00, ua_s.exp} - {2'b00, ub_s.exp} + 10'd127);
                    end
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            S_DIV: begin
                rem_d = qbit_s ? {trial_s[23:0], 1'b0} : {rem_q[23:0], 1'b0};
                quo_d = {quo_q[QBITS-2:0], qbit_s};
                cnt_d = (cnt_q == CNT_ZERO) ? CNT_ZERO : cnt_q - {{(CW-1){1'b0}}, 1'b1};
            end
            S_NORM: begin
                if (quo_q[QBITS-1]) begin
                    mant_d   = quo_q[QBITS-1 -: 24];
                    guard_d  = quo_q[1];
                    sticky_d = quo_q[0] || (rem_q != 25'd0);
                end else begin
                    mant_d   = quo_q[QBITS-2 -: 24];
                    guard_d  = quo_q[0];
                    sticky_d = (rem_q != 25'd0);
                    exp_d    = exp_q - 10'sd1;
                end
            end
            S_ROUND: begin
                out_valid_d = 1'b1;
                if (exp_rnd_s >= 10'sd255) begin
                    result_d = {sign_q, 8'hFF, 23'd0};
                    ovf_d    = 1'b1;
                end else if (exp_rnd_s <= 10'sd0) begin
                    result_d = {sign_q, 31'd0};
                    unf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_rnd_s[7:0], mant_rnd_s[22:0]};
                end
            end
            S_DONE: begin
                if (dbus.out_ready) begin
                    out_valid_d = 1'b0;
                    inv_d       = 1'b0;
                    dz_d        = 1'b0;
                    ovf_d       = 1'b0;
                    unf_d       = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= CNT_ZERO;
            rem_q       <= 25'd0;
            divisor_q   <= 24'd0;
            quo_q       <= {QBITS{1'b0}};
            exp_q       <= 10'sd0;
            sign_q      <= 1'b0;
            mant_q      <= 24'd0;
            guard_q     <= 1'b0;
            sticky_q    <= 1'b0;
            result_q    <= 32'd0;
            inv_q       <= 1'b0;
            dz_q        <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            quo_q       <= quo_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            mant_q      <= mant_d;
            guard_q     <= guard_d;
            sticky_q    <= sticky_d;
            result_q    <= result_d;
            inv_q       <= inv_d;
            dz_q        <= dz_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dbus.in_ready       = (state_q == S_IDLE);
    assign dbus.busy           = (state_q != S_IDLE);
    assign dbus.out_valid      = out_valid_q;
    assign dbus.result         = result_q;
    assign dbus.flag_invalid   = inv_q;
    assign dbus.flag_div_zero  = dz_q;
    assign dbus.flag_overflow  = ovf_q;
    assign dbus.flag_underflow = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed bench for fp_div_seq: exact-arithmetic reference model, per-cycle output compare,
// and hand-computed vectors for latency, specials, range limits, backpressure and mid-run reset.
module tb_fp_div_seq;
    logic clk;
    logic rst_n;
    logic chk_en;
    int   n_checks;
    int   n_errors;
    logic [35:0] m_exp;
    logic [3:0]  flags_s;

    fp_div_seq_if dbus ();

    fp_div_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dbus  (dbus)
    );

    assign flags_s = {dbus.flag_invalid, dbus.flag_div_zero, dbus.flag_overflow, dbus.flag_underflow};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer quotient with remainder-based RNE; flags {inv, dz, ovf, unf}.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        logic   s, za, zb, ia, ib, na, nb;
        longint ma, mb, num, m, r;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        za = (ea == 0);
        zb = (eb == 0);
        ia = (ea == 255) && (a[22:0] == 23'd0);
        ib = (eb == 255) && (b[22:0] == 23'd0);
        na = (ea == 255) && (a[22:0] != 23'd0);
        nb = (eb == 255) && (b[22:0] != 23'd0);
        if (na || nb || (za && zb) || (ia && ib)) return {32'h7FC00000, 4'b1000};
        if (ia) return {s, 8'hFF, 23'd0, 4'b0000};
        if (zb) return {s, 8'hFF, 23'd0, 4'b0100};
        if (za || ib) return {s, 31'd0, 4'b0000};
        ma = longint'({1'b1, a[22:0]});
        mb = longint'({1'b1, b[22:0]});
        e  = ea - eb + 127;
        if (ma < mb) begin
            ma = ma * 2;
            e  = e - 1;
        end
        num = ma << 23;
        m   = num / mb;
        r   = num % mb;
        if ((2 * r > mb) || ((2 * r == mb) && m[0])) m = m + 1;
        if (m == (longint'(1) << 24)) begin
            m = longint'(1) << 23;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0, 4'b0010};
        if (e <= 0) return {s, 31'd0, 4'b0001};
        return {s, e[7:0], m[22:0], 4'b0000};
    endfunction

    // Per-cycle compare against the model for the most recently issued operands.
    always @(negedge clk) begin
        if (chk_en) begin
            if (dbus.out_valid) begin
                chk("cmp_result", 64'(dbus.result), 64'(m_exp[35:4]));
                chk("cmp_flags", 64'(flags_s), 64'(m_exp[3:0]));
            end else begin
                chk("cmp_flags_idle", 64'(flags_s), 64'd0);
            end
            chk("cmp_ready_busy", 64'(dbus.in_ready), 64'(!dbus.busy));
        end
    end

    // elat: clock edges from the accept edge to the edge that raises out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                          input logic [3:0] ef, input int elat, input int hold);
        int n;
        chk("model_pin", 64'(model(a, b)), 64'({er, ef}));
        m_exp          = model(a, b);
        dbus.out_ready = (hold == 0);
        dbus.flp_a     = a;
        dbus.flp_b     = b;
        dbus.in_valid  = 1'b1;
        n = 0;
        while (!dbus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready", 64'(dbus.in_ready), 64'd1);
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        dbus.flp_a    = $urandom();
        dbus.flp_b    = $urandom();
        chk("in_ready_after_accept", 64'(dbus.in_ready), 64'd0);
        n = 0;
        while (!dbus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_seen", 64'(dbus.out_valid), 64'd1);
        chk("latency", 64'(n), 64'(elat));
        chk("result", 64'(dbus.result), 64'(er));
        chk("flags", 64'(flags_s), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            dbus.in_valid = i[0];
            dbus.flp_a    = 32'h3F800000;
            dbus.flp_b    = 32'h3F800000;
            @(posedge clk); #1;
            chk("bp_valid", 64'(dbus.out_valid), 64'd1);
            chk("bp_result", 64'(dbus.result), 64'(er));
            chk("bp_flags", 64'(flags_s), 64'(ef));
            chk("bp_in_ready", 64'(dbus.in_ready), 64'd0);
        end
        dbus.in_valid  = 1'b0;
        dbus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hs_valid", 64'(dbus.out_valid), 64'd0);
        chk("hs_in_ready", 64'(dbus.in_ready), 64'd1);
        chk("hs_flags", 64'(flags_s), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        chk_en         = 1'b0;
        m_exp          = 36'd0;
        rst_n          = 1'b0;
        dbus.in_valid  = 1'b0;
        dbus.out_ready = 1'b1;
        dbus.flp_a     = 32'd0;
        dbus.flp_b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", 64'(dbus.out_valid), 64'd0);
        chk("rst_result", 64'(dbus.result), 64'd0);
        chk("rst_flags", 64'(flags_s), 64'd0);
        chk("rst_in_ready", 64'(dbus.in_ready), 64'd1);
        chk("rst_busy", 64'(dbus.busy), 64'd0);
        chk_en = 1'b1;

        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 28, 0);
        run_op(32'hBF800000, 32'h40400000, 32'hBEAAAAAB, 4'b0000, 28, 0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 0, 0);
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 0, 0);
        run_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 0, 0);
        run_op(32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 0, 0);
        run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0, 0);
        run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0, 0);
        run_op(32'h3F800000, 32'h7F800000, 32'h00000000, 4'b0000, 0, 0);
        run_op(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0, 0);
        run_op(32'hBF800000, 32'h00000001, 32'hFF800000, 4'b0100, 0, 0);
        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 28, 0);
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 28, 0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 5);

        // Reset at DIV cycle 10 discards the operation.
        m_exp         = model(32'h40C00000, 32'h40000000);
        dbus.flp_a    = 32'h40C00000;
        dbus.flp_b    = 32'h40000000;
        dbus.in_valid = 1'b1;
        @(posedge clk); #1;
        dbus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("mid_div_busy", 64'(dbus.busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_out_valid", 64'(dbus.out_valid), 64'd0);
        chk("midrst_result", 64'(dbus.result), 64'd0);
        chk("midrst_in_ready", 64'(dbus.in_ready), 64'd1);
        chk("midrst_busy", 64'(dbus.busy), 64'd0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 28, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
